traffic_countdown: RTL and testbench
====================================

// Module: traffic_countdown
// PURPOSE
//  Downstream display stage for the traffic-light controller. Consumes the 6-bit light pattern, identifies
//  the current phase and shows the seconds remaining in that phase on the board's two static 7-seg digits.
//  Also checks the phase sequence and the phase durations, and raises a sticky fault on any violation.
//  Runs on the controller's 1 Hz tick clock. No scanning is needed because both digits are static.
// PARAMETERS
//  T_GREEN    10          A-green phase length in ticks (display start value); max 99
//  T_YELLOW   3           yellow phase length, both directions; max 99
//  T_RED      15          B-green phase length (A red); max 99
//  OVR_SLACK  1           extra ticks allowed at count 0 before overrun fault; range 0..3
//  CODE_AG    6'b110011   light pattern, A green
//  CODE_AY    6'b101011   light pattern, A yellow
//  CODE_BG    6'b011110   light pattern, B green
//  CODE_BY    6'b011101   light pattern, B yellow
// PORTS
//  clk1h     in   1  1 Hz tick clock, shared with the light controller
//  rst_n     in   1  synchronous, active-low reset; sampled on clk1h
//  light     in   6  registered light pattern from the controller
//  seg_tens  out  9  {dig_en_n, dp, g..a}; segments active-high, dig_en_n=0 lights the digit
//  seg_ones  out  9  same format as seg_tens, units digit
//  phase     out  2  0=AG 1=AY 2=BG 3=BY; valid only when locked=1
//  locked    out  1  1 while a valid phase is tracked
//  remain    out  7  binary remaining count (debug/verification)
//  fault     out  1  sticky sequence/duration/illegal-code error
// BEHAVIOUR
//  Reset (rst_n=0 at a clk1h edge):
//   - state=IDLE, remain=0, phase=0, locked=0, fault=0, light_q=0, ovr=0.
//   - seg_tens=seg_ones=9'h100 (blank).
//  light_q: registered copy of the last accepted valid code. "change" = light != light_q.
//  FSM states: IDLE, RUN, BLANK.
//   IDLE:
//    - valid code -> RUN; remain <= DUR(code), phase <= code's phase. No order check.
//    - invalid code -> stay IDLE, no fault.
//   RUN, valid change:
//    - remain <= DUR(new), phase updated, ovr <= 0.
//    - fault <= 1 if new phase != (phase+1) mod 4.
//    - fault <= 1 if remain != 0 at the change (early change).
//   RUN, no change:
//    - remain != 0: remain <= remain-1.
//    - remain == 0: hold 0, ovr <= ovr+1; fault <= 1 once ovr reaches OVR_SLACK.
//   RUN, invalid code: -> BLANK, fault <= 1, remain <= 0.
//   BLANK:
//    - valid code -> RUN, load as from IDLE, no order check.
//    - invalid code -> stay BLANK.
//  DUR mapping: AG=T_GREEN, AY=T_YELLOW, BG=T_RED, BY=T_YELLOW.
//  Latency: a new code appearing on light after edge k gives remain=DUR at edge k+1. Display follows
//   remain combinationally from registers, so it adds no further cycle.
//   A controller holding a phase DUR+1 ticks is therefore shown as DUR..0 with no fault.
//  Display:
//   - tens = remain/10, ones = remain%10 (remain <= 99 guaranteed).
//   - Tens digit is blanked when tens=0 (leading-zero suppression). Ones digit always lit when locked=1.
//   - locked=0 blanks both digits. DP is always 0.
//  fault clears only on reset. Reset mid-phase returns to IDLE; the next valid code relocks without fault.
//  Simultaneous change and remain==0 is the normal case: load only, no fault.
// STRUCTURE
//  - traffic_pkg: phase encodings, default light codes and durations, blank/segment constants,
//    function dur_of(phase).
//  - Sub-module seg7_decode: 4-bit BCD -> 7 segments g..a, active-high; codes 10..15 produce blank.
//    Instantiated twice.
//  - Top: FSM, light_q, remain counter, ovr counter, BCD split, digit enable/blank muxing.
// TESTING
//  1 Reset, then light=CODE_AG held 11 ticks, then CODE_AY:
//    remain 10,9..0 then 3; seg_ones shows 0 at the 10th tick after load; fault=0.
//  2 Full cycle AG(11)->AY(4)->BG(16)->BY(4)->AG, repeated twice:
//    phase 0,1,2,3,0; seg_tens lit only while remain>=10 (shows "1"); fault=0 throughout.
//  3 Early change, AG->AY after 6 ticks (remain=5): AY loaded (remain=3); fault=1 and stays 1.
//  4 Order violation, AG->BG at remain=0: remain=15, phase=2, fault=1.
//  5 Overrun, AG held 13 ticks with OVR_SLACK=1: remain stays 0, fault rises on the 2nd tick at 0.
//  6 Illegal code 6'b000000 while in RUN: both digits 9'h100, locked=0, fault=1.
//    Then CODE_BG relocks (remain=15). Assert rst_n=0 mid-phase: all outputs return to reset values.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic-light countdown display.
// It covers phase and FSM encodings, default light codes and durations, and segment constants.
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_AG = 2'd0,
    PH_AY = 2'd1,
    PH_BG = 2'd2,
    PH_BY = 2'd3
  } phase_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  localparam logic [5:0] CODE_AG_DEF = 6'b110011;
  localparam logic [5:0] CODE_AY_DEF = 6'b101011;
  localparam logic [5:0] CODE_BG_DEF = 6'b011110;
  localparam logic [5:0] CODE_BY_DEF = 6'b011101;

  localparam int unsigned T_GREEN_DEF  = 10;
  localparam int unsigned T_YELLOW_DEF = 3;
  localparam int unsigned T_RED_DEF    = 15;

  // {dig_en_n, dp, g..a}: digit disabled, all segments off
  localparam logic [8:0] SEG_BLANK = 9'h100;

  // Both yellow phases share one duration.
  function automatic logic [6:0] dur_of(input phase_t ph, input logic [6:0] t_green,
                                        input logic [6:0] t_yellow, input logic [6:0] t_red);
    case (ph)
      PH_AG:   dur_of = t_green;
      PH_BG:   dur_of = t_red;
      default: dur_of = t_yellow;
    endcase
  endfunction

endpackage

// File: rtl/traffic_countdown_seg7_decode.sv
// BCD to 7-segment decoder, active-high segments in g..a order.
// The non-decimal codes 10..15 decode to a blank digit.
module seg7_decode (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/traffic_countdown.sv
// Phase tracker and countdown display for the traffic-light controller.
// It checks the phase order and phase durations and latches any violation as a sticky fault.
module traffic_countdown
  import traffic_pkg::*;
#(
  parameter int unsigned T_GREEN   = T_GREEN_DEF,
  parameter int unsigned T_YELLOW  = T_YELLOW_DEF,
  parameter int unsigned T_RED     = T_RED_DEF,
  parameter int unsigned OVR_SLACK = 1,
  parameter logic [5:0]  CODE_AG   = CODE_AG_DEF,
  parameter logic [5:0]  CODE_AY   = CODE_AY_DEF,
  parameter logic [5:0]  CODE_BG   = CODE_BG_DEF,
  parameter logic [5:0]  CODE_BY   = CODE_BY_DEF
) (
  input  logic       clk1h,
  input  logic       rst_n,
  input  logic [5:0] light,
  output logic [8:0] seg_tens,
  output logic [8:0] seg_ones,
  output logic [1:0] phase,
  output logic       locked,
  output logic [6:0] remain,
  output logic       fault
);

  state_t     state_q, state_d;
  phase_t     phase_q, phase_d;
  logic [6:0] remain_q, remain_d;
  logic [5:0] light_q, light_d;
  logic [1:0] ovr_q, ovr_d;
  logic       fault_q, fault_d;

  logic       code_valid;
  phase_t     code_ph;
  logic [6:0] code_dur;

  always_comb begin
    code_valid = 1'b1;
    code_ph    = PH_AG;
    if (light == CODE_AG)      code_ph = PH_AG;
    else if (light == CODE_AY) code_ph = PH_AY;
    else if (light == CODE_BG) code_ph = PH_BG;
    else if (light == CODE_BY) code_ph = PH_BY;
    else                       code_valid = 1'b0;
    code_dur = dur_of(code_ph, 7'(T_GREEN), 7'(T_YELLOW), 7'(T_RED));
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    remain_d = remain_q;
    light_d  = light_q;
    ovr_d    = ovr_q;
    fault_d  = fault_q;
    case (state_q)
      ST_RUN: begin
        if (!code_valid) begin
          state_d  = ST_BLANK;
          fault_d  = 1'b1;
          remain_d = 7'd0;
          ovr_d    = 2'd0;
        end else if (light != light_q) begin
          // A change with the count already at zero is the normal hand-over.
          remain_d = code_dur;
          phase_d  = code_ph;
          light_d  = light;
          ovr_d    = 2'd0;
          if (code_ph != phase_t'(phase_q + 2'd1)) fault_d = 1'b1;
          if (remain_q != 7'd0) fault_d = 1'b1;
        end else if (remain_q != 7'd0) begin
          remain_d = remain_q - 7'd1;
        end else begin
          if (ovr_q >= 2'(OVR_SLACK)) fault_d = 1'b1;
          if (ovr_q != 2'd3) ovr_d = ovr_q + 2'd1;
        end
      end
      default: begin
        // IDLE and BLANK both lock on to any valid code, without an order check.
        if (code_valid) begin
          state_d  = ST_RUN;
          remain_d = code_dur;
          phase_d  = code_ph;
          light_d  = light;
          ovr_d    = 2'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk1h) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      phase_q  <= PH_AG;
      remain_q <= 7'd0;
      light_q  <= 6'd0;
      ovr_q    <= 2'd0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      remain_q <= remain_d;
      light_q  <= light_d;
      ovr_q    <= ovr_d;
      fault_q  <= fault_d;
    end
  end

  logic [3:0] digit   [2];
  logic [6:0] seg_raw [2];

  assign digit[0] = 4'(remain_q % 7'd10);
  assign digit[1] = 4'(remain_q / 7'd10);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dec
      seg7_decode u_dec (
        .bcd (digit[gi]),
        .seg (seg_raw[gi])
      );
    end
  endgenerate

  assign locked   = (state_q == ST_RUN);
  assign phase    = phase_q;
  assign remain   = remain_q;
  assign fault    = fault_q;
  assign seg_ones = locked ? {2'b00, seg_raw[0]} : SEG_BLANK;
  assign seg_tens = (locked && digit[1] != 4'd0) ? {2'b00, seg_raw[1]} : SEG_BLANK;

endmodule

// File: tb/tb_traffic_countdown.sv
// Directed bench for traffic_countdown, with hand-computed expected values.
// It covers reset, the normal cycle, early change, order violation, overrun and illegal-code cases.
module tb_traffic_countdown;

  localparam logic [5:0] AG = 6'b110011;
  localparam logic [5:0] AY = 6'b101011;
  localparam logic [5:0] BG = 6'b011110;
  localparam logic [5:0] BY = 6'b011101;
  localparam logic [8:0] BLK = 9'h100;
  localparam logic [8:0] TEN = 9'h006;

  logic       clk1h = 1'b0;
  logic       rst_n;
  logic [5:0] light;
  logic [8:0] seg_tens, seg_ones;
  logic [1:0] phase;
  logic       locked, fault;
  logic [6:0] remain;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int n_vec = 0;
  int n_err = 0;

  traffic_countdown dut (
    .clk1h    (clk1h),
    .rst_n    (rst_n),
    .light    (light),
    .seg_tens (seg_tens),
    .seg_ones (seg_ones),
    .phase    (phase),
    .locked   (locked),
    .remain   (remain),
    .fault    (fault)
  );

  always #5 clk1h = ~clk1h;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk1h);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    light = 6'd0;
    tick();
    rst_n = 1'b1;
  endtask

  // Checks remain, both digits and fault for one tick of a fault-free count.
  task automatic chk_count(input string tag, input int r);
    logic [8:0] exp_ones;
    exp_ones = {2'b00, seg_tab[r % 10]};
    chk({tag, ".remain"}, 32'(remain), 32'(r));
    chk({tag, ".ones"}, 32'(seg_ones), 32'(exp_ones));
    chk({tag, ".tens"}, 32'(seg_tens), 32'((r >= 10) ? TEN : BLK));
    chk({tag, ".fault"}, 32'(fault), 32'd0);
  endtask

  // Holds one code for dur+1 ticks and checks the whole countdown.
  task automatic run_phase(input logic [5:0] code, input int dur, input int ph);
    light = code;
    tick();
    chk("cyc.phase", 32'(phase), 32'(ph));
    chk("cyc.locked", 32'(locked), 32'd1);
    chk_count("cyc.load", dur);
    for (int r = dur - 1; r >= 0; r--) begin
      tick();
      chk_count("cyc.cnt", r);
    end
    $display("phase %0d held %0d ticks", ph, dur + 1);
  endtask

  initial begin
    rst_n = 1'b0;
    light = 6'd0;
    tick();
    tick();
    chk("rst.remain", 32'(remain), 32'd0);
    chk("rst.phase", 32'(phase), 32'd0);
    chk("rst.locked", 32'(locked), 32'd0);
    chk("rst.fault", 32'(fault), 32'd0);
    chk("rst.tens", 32'(seg_tens), 32'(BLK));
    chk("rst.ones", 32'(seg_ones), 32'(BLK));
    rst_n = 1'b1;
    $display("reset checked");

    // 1: AG for 11 ticks, then AY
    light = AG;
    tick();
    chk("t1.locked", 32'(locked), 32'd1);
    chk("t1.phase", 32'(phase), 32'd0);
    chk("t1.tens", 32'(seg_tens), 32'(TEN));
    chk("t1.ones", 32'(seg_ones), 32'h03F);
    chk("t1.remain", 32'(remain), 32'd10);
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("t1.remain", 32'(remain), 32'(10 - i));
    end
    chk("t1.ones0", 32'(seg_ones), 32'h03F);
    chk("t1.tens0", 32'(seg_tens), 32'(BLK));
    light = AY;
    tick();
    chk("t1.ay.remain", 32'(remain), 32'd3);
    chk("t1.ay.phase", 32'(phase), 32'd1);
    chk("t1.ay.ones", 32'(seg_ones), 32'h04F);
    chk("t1.fault", 32'(fault), 32'd0);
    $display("test 1 done");

    // 2: two full cycles, then back to AG
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      run_phase(AG, 10, 0);
      run_phase(AY, 3, 1);
      run_phase(BG, 15, 2);
      run_phase(BY, 3, 3);
    end
    light = AG;
    tick();
    chk("t2.wrap.phase", 32'(phase), 32'd0);
    chk("t2.wrap.remain", 32'(remain), 32'd10);
    chk("t2.wrap.fault", 32'(fault), 32'd0);
    $display("test 2 done");

    // 3: early change at remain=5
    do_reset();
    light = AG;
    tick();
    for (int i = 0; i < 5; i++) tick();
    chk("t3.pre.remain", 32'(remain), 32'd5);
    chk("t3.pre.fault", 32'(fault), 32'd0);
    light = AY;
    tick();
    chk("t3.remain", 32'(remain), 32'd3);
    chk("t3.phase", 32'(phase), 32'd1);
    chk("t3.fault", 32'(fault), 32'd1);
    tick();
    chk("t3.sticky", 32'(fault), 32'd1);
    chk("t3.remain2", 32'(remain), 32'd2);
    $display("test 3 done");

    // 4: order violation AG -> BG at remain=0
    do_reset();
    chk("t4.rst.fault", 32'(fault), 32'd0);
    light = AG;
    tick();
    for (int i = 0; i < 10; i++) tick();
    chk("t4.pre.remain", 32'(remain), 32'd0);
    light = BG;
    tick();
    chk("t4.remain", 32'(remain), 32'd15);
    chk("t4.phase", 32'(phase), 32'd2);
    chk("t4.fault", 32'(fault), 32'd1);
    $display("test 4 done");

    // 5: overrun, AG held 13 ticks
    do_reset();
    light = AG;
    tick();
    for (int i = 0; i < 10; i++) tick();
    chk("t5.t11.remain", 32'(remain), 32'd0);
    chk("t5.t11.fault", 32'(fault), 32'd0);
    tick();
    chk("t5.t12.remain", 32'(remain), 32'd0);
    chk("t5.t12.fault", 32'(fault), 32'd0);
    tick();
    chk("t5.t13.remain", 32'(remain), 32'd0);
    chk("t5.t13.fault", 32'(fault), 32'd1);
    $display("test 5 done");

    // 6: illegal code, relock, then mid-phase reset
    do_reset();
    light = AG;
    tick();
    tick();
    light = 6'b000000;
    tick();
    chk("t6.tens", 32'(seg_tens), 32'(BLK));
    chk("t6.ones", 32'(seg_ones), 32'(BLK));
    chk("t6.locked", 32'(locked), 32'd0);
    chk("t6.fault", 32'(fault), 32'd1);
    chk("t6.remain", 32'(remain), 32'd0);
    tick();
    chk("t6.blank.locked", 32'(locked), 32'd0);
    light = BG;
    tick();
    chk("t6.relock.remain", 32'(remain), 32'd15);
    chk("t6.relock.locked", 32'(locked), 32'd1);
    chk("t6.relock.phase", 32'(phase), 32'd2);
    chk("t6.relock.fault", 32'(fault), 32'd1);
    tick();
    rst_n = 1'b0;
    tick();
    chk("t6.rst.remain", 32'(remain), 32'd0);
    chk("t6.rst.phase", 32'(phase), 32'd0);
    chk("t6.rst.locked", 32'(locked), 32'd0);
    chk("t6.rst.fault", 32'(fault), 32'd0);
    chk("t6.rst.tens", 32'(seg_tens), 32'(BLK));
    chk("t6.rst.ones", 32'(seg_ones), 32'(BLK));
    rst_n = 1'b1;
    light = AG;
    tick();
    chk("t6.again.remain", 32'(remain), 32'd10);
    chk("t6.again.fault", 32'(fault), 32'd0);
    $display("test 6 done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
